// File: rtl/regbank_write_arbiter.sv
// Arbitrates the register bank write port between WB and a queued AUX path (FIFO + starvation drain).
// Optional REGBANK_ARB_FWD_EN adds a lookup port that exposes queued AUX results for bypass.
module regbank_write_arbiter #(
   parameter int AUX_DEPTH = 2,
   parameter int MAX_WAIT  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wb_valid,
   input  logic [4:0]                   wb_dest,
   input  logic [31:0]                  wb_data,
   output logic                         wb_stall,
   input  logic                         aux_valid,
   input  logic [4:0]                   aux_dest,
   input  logic [31:0]                  aux_data,
   output logic                         aux_ready,
   output logic                         VaiEscrever,
   output logic [4:0]                   destinoDoescreverData,
   output logic [31:0]                  wdataValor,
`ifdef REGBANK_ARB_FWD_EN
   input  logic [4:0]                   fwd_reg,
   output logic                         fwd_hit,
   output logic [31:0]                  fwd_data,
`endif
   output logic [$clog2(AUX_DEPTH):0]   pend_count
);

   localparam int PW = $clog2(AUX_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(MAX_WAIT + 1);

   logic [4:0]           fdest_q [AUX_DEPTH];
   logic [31:0]          fdata_q [AUX_DEPTH];
   logic [AUX_DEPTH-1:0] fvld_q;
   logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]        count_q, count_d;
   logic [SW-1:0]        starve_q, starve_d;
   logic                 we_q, we_d;
   logic [4:0]           waddr_q, waddr_d;
   logic [31:0]          wdata_q, wdata_d;

   logic empty, full, push, pop, wb_req, wb_grant, force_drain;

   always_comb begin
      empty       = (count_q == '0);
      full        = (count_q == CW'(AUX_DEPTH));
      aux_ready   = !full;
      wb_req      = wb_valid && (wb_dest != 5'd0);
      push        = aux_valid && !full && (aux_dest != 5'd0);
      force_drain = !empty && (starve_q >= SW'(MAX_WAIT));

      pop      = 1'b0;
      wb_grant = 1'b0;
      wb_stall = 1'b0;
      if (force_drain) begin
         pop      = 1'b1;
         wb_stall = wb_req;
      end else if (wb_req) begin
         wb_grant = 1'b1;
      end else if (!empty) begin
         pop = 1'b1;
      end

      // An invalidated head still consumes the slot but leaves address/data untouched.
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (wb_grant) begin
         we_d    = 1'b1;
         waddr_d = wb_dest;
         wdata_d = wb_data;
      end else if (pop && fvld_q[rd_ptr_q]) begin
         we_d    = 1'b1;
         waddr_d = fdest_q[rd_ptr_q];
         wdata_d = fdata_q[rd_ptr_q];
      end

      count_d = count_q + CW'(push) - CW'(pop);

      if (empty || pop)
         starve_d = '0;
      else if (starve_q != SW'(MAX_WAIT))
         starve_d = starve_q + SW'(1);
      else
         starve_d = starve_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         fvld_q   <= '0;
         we_q     <= 1'b0;
         waddr_q  <= 5'd0;
         wdata_q  <= 32'd0;
      end else begin
         count_q  <= count_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         if (pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push)
            wr_ptr_q <= wr_ptr_q + PW'(1);
         // WB is younger than anything already queued; a same-cycle push lands after and stays valid.
         for (int i = 0; i < AUX_DEPTH; i++) begin
            if (wb_grant && (fdest_q[i] == wb_dest))
               fvld_q[i] <= 1'b0;
         end
         if (push)
            fvld_q[wr_ptr_q] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fdest_q[wr_ptr_q] <= aux_dest;
         fdata_q[wr_ptr_q] <= aux_data;
      end
   end

`ifdef REGBANK_ARB_FWD_EN
   logic [PW-1:0] fwd_idx;

   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = 32'd0;
      fwd_idx  = rd_ptr_q;
      // Walk oldest to youngest so the last match wins.
      for (int i = 0; i < AUX_DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && fvld_q[fwd_idx] && (fdest_q[fwd_idx] == fwd_reg) &&
             (fwd_reg != 5'd0)) begin
            fwd_hit  = 1'b1;
            fwd_data = fdata_q[fwd_idx];
         end
      end
   end
`endif

   assign VaiEscrever           = we_q;
   assign destinoDoescreverData = waddr_q;
   assign wdataValor            = wdata_q;
   assign pend_count            = count_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed self-checking bench for regbank_write_arbiter (AUX_DEPTH=2, MAX_WAIT=4).
module tb_regbank_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid, aux_valid;
   logic [4:0]  wb_dest, aux_dest;
   logic [31:0] wb_data, aux_data;
   logic        wb_stall, aux_ready, VaiEscrever;
   logic [4:0]  destinoDoescreverData;
   logic [31:0] wdataValor;
   logic [1:0]  pend_count;
`ifdef REGBANK_ARB_FWD_EN
   logic [4:0]  fwd_reg = 5'd0;
   logic        fwd_hit;
   logic [31:0] fwd_data;
`endif

   int checks = 0;
   int errors = 0;

   regbank_write_arbiter #(.AUX_DEPTH(2), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_stall(wb_stall),
      .aux_valid(aux_valid), .aux_dest(aux_dest), .aux_data(aux_data), .aux_ready(aux_ready),
      .VaiEscrever(VaiEscrever), .destinoDoescreverData(destinoDoescreverData),
      .wdataValor(wdataValor),
`ifdef REGBANK_ARB_FWD_EN
      .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
      .pend_count(pend_count)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_valid = 1'b0; wb_dest = 5'd0; wb_data = 32'd0;
      aux_valid = 1'b0; aux_dest = 5'd0; aux_data = 32'd0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic wb(input logic [4:0] d, input logic [31:0] v);
      wb_valid = 1'b1; wb_dest = d; wb_data = v;
   endtask

   task automatic aux(input logic [4:0] d, input logic [31:0] v);
      aux_valid = 1'b1; aux_dest = d; aux_data = v;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (VaiEscrever !== 1'b0 || destinoDoescreverData !== 5'd0 || wdataValor !== 32'd0) begin
         errors++; $display("FAIL reset_outputs got we=%0b dest=%0d data=%h exp 0/0/0",
                            VaiEscrever, destinoDoescreverData, wdataValor);
      end
      checks++;
      if (pend_count !== 2'd0 || aux_ready !== 1'b1 || wb_stall !== 1'b0) begin
         errors++; $display("FAIL reset_status got pend=%0d ready=%0b stall=%0b exp 0/1/0",
                            pend_count, aux_ready, wb_stall);
      end
   endtask

   task automatic test_wb_only();
      do_reset();
      wb(5'd5, 32'hDEADBEEF);
      #1;
      checks++;
      if (wb_stall !== 1'b0) begin errors++; $display("FAIL wb_only_stall got %0b exp 0", wb_stall); end
      cyc();
      idle();
      checks++;
      if (VaiEscrever !== 1'b1 || destinoDoescreverData !== 5'd5 || wdataValor !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wb_only_write got we=%0b dest=%0d data=%h exp 1/5/deadbeef",
                            VaiEscrever, destinoDoescreverData, wdataValor);
      end
      cyc();
      checks++;
      if (VaiEscrever !== 1'b0 || destinoDoescreverData !== 5'd5 || wdataValor !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wb_only_hold got we=%0b dest=%0d data=%h exp 0/5/deadbeef",
                            VaiEscrever, destinoDoescreverData, wdataValor);
      end
      // dest 0 requests are never written
      wb(5'd0, 32'h1234);
      cyc();
      idle();
      checks++;
      if (VaiEscrever !== 1'b0) begin errors++; $display("FAIL wb_zero_dest got we=%0b exp 0", VaiEscrever); end
   endtask

   task automatic test_aux_idle();
      do_reset();
      aux(5'd7, 32'h11);
      cyc();
      idle();
      checks++;
      if (pend_count !== 2'd1 || VaiEscrever !== 1'b0) begin
         errors++; $display("FAIL aux_queued got pend=%0d we=%0b exp 1/0", pend_count, VaiEscrever);
      end
      cyc();
      checks++;
      if (pend_count !== 2'd0 || VaiEscrever !== 1'b1 || destinoDoescreverData !== 5'd7 ||
          wdataValor !== 32'h11) begin
         errors++; $display("FAIL aux_write got pend=%0d we=%0b dest=%0d data=%h exp 0/1/7/11",
                            pend_count, VaiEscrever, destinoDoescreverData, wdataValor);
      end
      aux(5'd0, 32'h55);
      #1;
      checks++;
      if (aux_ready !== 1'b1) begin errors++; $display("FAIL aux_zero_ready got %0b exp 1", aux_ready); end
      cyc();
      idle();
      checks++;
      if (pend_count !== 2'd0) begin errors++; $display("FAIL aux_zero_discard got pend=%0d exp 0", pend_count); end
   endtask

   task automatic test_starvation();
      do_reset();
      wb(5'd1, 32'd100);
      aux(5'd3, 32'h33);
      cyc();
      aux_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         wb(5'd1, 32'd100 + 32'(k));
         #1;
         checks++;
         if (wb_stall !== 1'b0) begin errors++; $display("FAIL starve_nostall_%0d got %0b exp 0", k, wb_stall); end
         cyc();
         checks++;
         if (VaiEscrever !== 1'b1 || destinoDoescreverData !== 5'd1 || wdataValor !== 32'd100 + 32'(k)) begin
            errors++; $display("FAIL starve_wb_%0d got we=%0b dest=%0d data=%0d exp 1/1/%0d",
                               k, VaiEscrever, destinoDoescreverData, wdataValor, 100 + k);
         end
      end
      wb(5'd1, 32'd105);
      #1;
      checks++;
      if (wb_stall !== 1'b1) begin errors++; $display("FAIL starve_stall got %0b exp 1", wb_stall); end
      cyc();
      checks++;
      if (VaiEscrever !== 1'b1 || destinoDoescreverData !== 5'd3 || wdataValor !== 32'h33 || pend_count !== 2'd0) begin
         errors++; $display("FAIL starve_drain got we=%0b dest=%0d data=%h pend=%0d exp 1/3/33/0",
                            VaiEscrever, destinoDoescreverData, wdataValor, pend_count);
      end
      checks++;
      if (wb_stall !== 1'b0) begin errors++; $display("FAIL starve_release got %0b exp 0", wb_stall); end
      cyc();
      idle();
      checks++;
      if (VaiEscrever !== 1'b1 || destinoDoescreverData !== 5'd1 || wdataValor !== 32'd105) begin
         errors++; $display("FAIL starve_retry got we=%0b dest=%0d data=%0d exp 1/1/105",
                            VaiEscrever, destinoDoescreverData, wdataValor);
      end
   endtask

   task automatic test_full();
      do_reset();
      wb(5'd2, 32'h20);
      aux(5'd10, 32'h1);
      cyc();
      aux(5'd11, 32'h2);
      cyc();
      aux(5'd12, 32'h3);
      #1;
      checks++;
      if (aux_ready !== 1'b0 || pend_count !== 2'd2) begin
         errors++; $display("FAIL full_ready got ready=%0b pend=%0d exp 0/2", aux_ready, pend_count);
      end
      cyc();
      checks++;
      if (pend_count !== 2'd2) begin errors++; $display("FAIL full_held got pend=%0d exp 2", pend_count); end
      // WB released: pop happens but full blocks the push in the same cycle
      wb_valid = 1'b0;
      #1;
      checks++;
      if (aux_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %0b exp 0", aux_ready); end
      cyc();
      checks++;
      if (pend_count !== 2'd1 || VaiEscrever !== 1'b1 || destinoDoescreverData !== 5'd10) begin
         errors++; $display("FAIL full_pop1 got pend=%0d we=%0b dest=%0d exp 1/1/10",
                            pend_count, VaiEscrever, destinoDoescreverData);
      end
      cyc();
      idle();
      checks++;
      if (pend_count !== 2'd1 || destinoDoescreverData !== 5'd11 || wdataValor !== 32'h2) begin
         errors++; $display("FAIL full_pop2 got pend=%0d dest=%0d data=%h exp 1/11/2",
                            pend_count, destinoDoescreverData, wdataValor);
      end
      cyc();
      checks++;
      if (pend_count !== 2'd0 || VaiEscrever !== 1'b1 || destinoDoescreverData !== 5'd12 || wdataValor !== 32'h3) begin
         errors++; $display("FAIL full_pop3 got pend=%0d we=%0b dest=%0d data=%h exp 0/1/12/3",
                            pend_count, VaiEscrever, destinoDoescreverData, wdataValor);
      end
   endtask

   task automatic test_ordering();
      do_reset();
      wb(5'd4, 32'h44);
      aux(5'd9, 32'hA);
      cyc();
      aux_valid = 1'b0;
      wb(5'd9, 32'hB);
      cyc();
      idle();
      checks++;
      if (VaiEscrever !== 1'b1 || destinoDoescreverData !== 5'd9 || wdataValor !== 32'hB) begin
         errors++; $display("FAIL order_wb got we=%0b dest=%0d data=%h exp 1/9/b",
                            VaiEscrever, destinoDoescreverData, wdataValor);
      end
      cyc();
      checks++;
      if (VaiEscrever !== 1'b0 || pend_count !== 2'd0 || wdataValor !== 32'hB) begin
         errors++; $display("FAIL order_killed got we=%0b pend=%0d data=%h exp 0/0/b",
                            VaiEscrever, pend_count, wdataValor);
      end
      // same-cycle push to the WB destination survives
      wb(5'd6, 32'h66);
      aux(5'd6, 32'h77);
      cyc();
      idle();
      checks++;
      if (VaiEscrever !== 1'b1 || destinoDoescreverData !== 5'd6 || wdataValor !== 32'h66) begin
         errors++; $display("FAIL order_same_wb got we=%0b dest=%0d data=%h exp 1/6/66",
                            VaiEscrever, destinoDoescreverData, wdataValor);
      end
      cyc();
      checks++;
      if (VaiEscrever !== 1'b1 || destinoDoescreverData !== 5'd6 || wdataValor !== 32'h77) begin
         errors++; $display("FAIL order_same_aux got we=%0b dest=%0d data=%h exp 1/6/77",
                            VaiEscrever, destinoDoescreverData, wdataValor);
      end
   endtask

`ifdef REGBANK_ARB_FWD_EN
   task automatic test_forward();
      do_reset();
      wb(5'd2, 32'h20);
      aux(5'd7, 32'h11);
      cyc();
      aux_valid = 1'b0;
      fwd_reg = 5'd7;
      #1;
      checks++;
      if (fwd_hit !== 1'b1 || fwd_data !== 32'h11) begin
         errors++; $display("FAIL fwd_hit got hit=%0b data=%h exp 1/11", fwd_hit, fwd_data);
      end
      fwd_reg = 5'd8;
      #1;
      checks++;
      if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
         errors++; $display("FAIL fwd_miss got hit=%0b data=%h exp 0/0", fwd_hit, fwd_data);
      end
      fwd_reg = 5'd0;
      idle();
   endtask
`endif

   task automatic test_reset_mid();
      do_reset();
      wb(5'd2, 32'h20);
      aux(5'd13, 32'h5);
      cyc();
      aux(5'd14, 32'h6);
      cyc();
      checks++;
      if (pend_count !== 2'd2) begin errors++; $display("FAIL mid_fill got pend=%0d exp 2", pend_count); end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      idle();
      checks++;
      if (pend_count !== 2'd0 || VaiEscrever !== 1'b0 || aux_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset got pend=%0d we=%0b ready=%0b exp 0/0/1",
                            pend_count, VaiEscrever, aux_ready);
      end
      cyc();
      checks++;
      if (VaiEscrever !== 1'b0 || pend_count !== 2'd0) begin
         errors++; $display("FAIL mid_after got we=%0b pend=%0d exp 0/0", VaiEscrever, pend_count);
      end
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_wb_only();
      test_aux_idle();
      test_starvation();
      test_full();
      test_ordering();
`ifdef REGBANK_ARB_FWD_EN
      test_forward();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
